// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - central hazard sequencer for the 16-bit five-stage pipeline
//
// Drives the IF/ID, ID/EX and EX/M buffer enables and flushes from four hazard
// sources: taken branches resolved in EX, multi-cycle multiply/divide in EX,
// load-use dependences between EX and ID, and the halt opcode in ID.
// Also keeps a saturating count of front-end stall cycles.
//
// Optional feature macro: MULDIV_STALL_EN
//   defined   - IDEX_MulDiv holds the op in EX for MULDIV_CYCLES total cycles
//   undefined - IDEX_MulDiv is ignored, EX_Hold is tied low, md_cnt is absent
//
// Parameters:
//   MULDIV_CYCLES  total EX occupancy of a multiply/divide op (2..15)
//   HALT_OPCODE    opcode that stops fetch
//
// Ports:
//   clk           pipeline clock, rising edge
//   reset         asynchronous active-low reset
//   IFID_opcode   opcode of the instruction in ID
//   IFID_Fop1     first source register of the instruction in ID
//   IFID_Fop2     second source register of the instruction in ID
//   IDEX_RegRD    destination register of the instruction in EX
//   IDEX_MemRead  instruction in EX is a load
//   IDEX_MulDiv   instruction in EX is multiply/divide
//   PCSRC         branch taken, resolved in EX
//   PCWrite       PC load enable
//   IFID_Write    IF/ID load enable
//   IFID_FLUSH    IF/ID loads a NOP
//   IDEX_FLUSH    ID/EX loads a bubble
//   EX_Hold       ID/EX holds, EX/M loads a bubble
//   STALL         front end frozen this cycle
//   halted        halt reached
//   stall_count   saturating count of STALL cycles

module pipeline_ctrl #(
    parameter int         MULDIV_CYCLES = 4,
    parameter logic [3:0] HALT_OPCODE   = 4'hF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  IFID_opcode,
    input  logic [3:0]  IFID_Fop1,
    input  logic [3:0]  IFID_Fop2,
    input  logic [3:0]  IDEX_RegRD,
    input  logic        IDEX_MemRead,
    input  logic        IDEX_MulDiv,
    input  logic        PCSRC,
    output logic        PCWrite,
    output logic        IFID_Write,
    output logic        IFID_FLUSH,
    output logic        IDEX_FLUSH,
    output logic        EX_Hold,
    output logic        STALL,
    output logic        halted,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LD_BUBBLE = 2'd1,
        MD_WAIT   = 2'd2,
        HALT      = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic load_use;
    logic is_halt_op;
    logic md_start;
    logic md_event;

`ifdef MULDIV_STALL_EN
    localparam logic [3:0] MD_LOAD = 4'(MULDIV_CYCLES - 2);
    logic [3:0] md_cnt;
    assign md_event = IDEX_MulDiv;
`else
    logic unused_muldiv;
    assign md_event      = 1'b0;
    assign unused_muldiv = IDEX_MulDiv ^ (MULDIV_CYCLES == 0);
`endif

    // R0 is deliberately not excluded: a load to R0 still stalls a reader of R0.
    assign load_use   = IDEX_MemRead &&
                        ((IDEX_RegRD == IFID_Fop1) || (IDEX_RegRD == IFID_Fop2));
    assign is_halt_op = (IFID_opcode == HALT_OPCODE);

    // Hazard outputs are combinational so every hazard is answered in the
    // cycle it is detected.
    always_comb begin
        PCWrite    = 1'b1;
        IFID_Write = 1'b1;
        IFID_FLUSH = 1'b0;
        IDEX_FLUSH = 1'b0;
        EX_Hold    = 1'b0;
        STALL      = 1'b0;
        halted     = 1'b0;
        md_start   = 1'b0;
        next_state = state;

        case (state)
            RUN, LD_BUBBLE: begin
                if (PCSRC) begin
                    // Wrong-path instructions in IF and ID are squashed; any
                    // hazard they raise is meaningless.
                    IFID_FLUSH = 1'b1;
                    IDEX_FLUSH = 1'b1;
                    next_state = RUN;
                end else if (md_event) begin
                    PCWrite    = 1'b0;
                    IFID_Write = 1'b0;
                    EX_Hold    = 1'b1;
                    STALL      = 1'b1;
                    md_start   = 1'b1;
                    next_state = MD_WAIT;
                end else if ((state == RUN) && load_use) begin
                    // The bubble cycle that follows sees the same ID instruction
                    // against the bubble in EX, so detection is masked there.
                    PCWrite    = 1'b0;
                    IFID_Write = 1'b0;
                    IDEX_FLUSH = 1'b1;
                    STALL      = 1'b1;
                    next_state = LD_BUBBLE;
                end else if (is_halt_op) begin
                    PCWrite    = 1'b0;
                    IFID_Write = 1'b0;
                    IDEX_FLUSH = 1'b1;
                    next_state = HALT;
                end else begin
                    next_state = RUN;
                end
            end

            MD_WAIT: begin
`ifdef MULDIV_STALL_EN
                if (md_cnt != 4'd0) begin
                    PCWrite    = 1'b0;
                    IFID_Write = 1'b0;
                    EX_Hold    = 1'b1;
                    STALL      = 1'b1;
                end else begin
                    next_state = RUN;
                end
`else
                next_state = RUN;
`endif
            end

            HALT: begin
                // Older instructions drain; only reset leaves this state.
                PCWrite    = 1'b0;
                IFID_Write = 1'b0;
                IDEX_FLUSH = 1'b1;
                halted     = 1'b1;
            end

            default: begin
                next_state = RUN;
            end
        endcase

        if (!reset) begin
            PCWrite    = 1'b0;
            IFID_Write = 1'b0;
            IFID_FLUSH = 1'b1;
            IDEX_FLUSH = 1'b1;
            EX_Hold    = 1'b0;
            STALL      = 1'b0;
            halted     = 1'b0;
            md_start   = 1'b0;
            next_state = RUN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RUN;
            stall_count <= 16'd0;
        end else begin
            state <= next_state;
            if (STALL && (state != HALT) && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end

`ifdef MULDIV_STALL_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_cnt <= 4'd0;
        end else if (md_start) begin
            md_cnt <= MD_LOAD;
        end else if ((state == MD_WAIT) && (md_cnt != 4'd0)) begin
            md_cnt <= md_cnt - 4'd1;
        end
    end
`else
    logic unused_md_start;
    assign unused_md_start = md_start;
`endif

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central pipeline sequencer for the 16-bit five-stage CPU. Sits beside the IF/ID, ID/EX and EX/M buffers and drives their write-enable and flush controls from hazard sources: load-use dependences, taken branches resolved in EX, multi-cycle multiply/divide ops, and the halt opcode. It absorbs the standalone hazard-detection role and adds a small FSM plus a stall-cycle performance counter.

## Interface
Parameters:
- MULDIV_CYCLES, 4, total EX occupancy of a multiply/divide op; legal range 2..15
- HALT_OPCODE, 4'hF, opcode that stops fetch

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low reset
- IFID_opcode  in  4  opcode of instruction in ID
- IFID_Fop1  in  4  first source register of instruction in ID
- IFID_Fop2  in  4  second source register of instruction in ID
- IDEX_RegRD  in  4  destination register of instruction in EX
- IDEX_MemRead  in  1  instruction in EX is a load
- IDEX_MulDiv  in  1  instruction in EX is multiply/divide
- PCSRC  in  1  branch taken, resolved in EX
- PCWrite  out  1  PC register load enable
- IFID_Write  out  1  IF/ID buffer load enable
- IFID_FLUSH  out  1  IF/ID loads a NOP
- IDEX_FLUSH  out  1  ID/EX loads a bubble (all control bits 0)
- EX_Hold  out  1  ID/EX holds contents; EX/M loads a bubble
- STALL  out  1  front end frozen this cycle
- halted  out  1  halt reached
- stall_count  out  16  saturating count of STALL cycles

## Operation
- FSM states: RUN, LD_BUBBLE, MD_WAIT, HALT. 4-bit down-counter md_cnt.
- Default outputs (RUN, no event): PCWrite=1, IFID_Write=1, all flushes/holds/STALL=0.
- Event priority in RUN: PCSRC > IDEX_MulDiv > load-use > halt.
- Taken branch (PCSRC=1): IFID_FLUSH=1, IDEX_FLUSH=1, PCWrite=1 (target loaded); next RUN. Pending load-use/halt in same cycle ignored (wrong path).
- Load-use: IDEX_MemRead=1 and IDEX_RegRD equals IFID_Fop1 or IFID_Fop2 (R0 included, no exclusion). Same cycle: PCWrite=0, IFID_Write=0, IDEX_FLUSH=1, STALL=1; next LD_BUBBLE.
- LD_BUBBLE: default outputs, load-use detection suppressed; next RUN. Halt and PCSRC evaluated as in RUN.
- Multiply/divide (feature-gated): detection cycle PCWrite=0, IFID_Write=0, EX_Hold=1, STALL=1, md_cnt<=MULDIV_CYCLES-2; next MD_WAIT.
- MD_WAIT: if md_cnt!=0, hold outputs as detection cycle, md_cnt decrements. If md_cnt==0, default outputs (op retires), next RUN. PCSRC, load-use and halt ignored in MD_WAIT.
- Halt: IFID_opcode==HALT_OPCODE in RUN/LD_BUBBLE, no higher event: IDEX_FLUSH=1, PCWrite=0, IFID_Write=0; next HALT.
- HALT: PCWrite=0, IFID_Write=0, IDEX_FLUSH=1, halted=1, STALL=0; older instructions drain through EX/M/WB. Exit only via reset.
- stall_count increments on each clock edge where STALL=1; saturates at 16'hFFFF; never counts in HALT.

## Timing
- All hazard outputs are combinational from state plus inputs: zero-cycle response in the detection cycle.
- State, md_cnt, stall_count register on rising clk.
- Load-use cost: exactly 1 stall cycle. Branch cost: 2 flushed slots, 0 stall cycles. Mul/div cost: MULDIV_CYCLES-1 stall cycles.
- Back-to-back mul/div: second op detected in the RUN cycle after the first retires.
- While reset low (asynchronous): state=RUN, md_cnt=0, stall_count=0, PCWrite=0, IFID_Write=0, IFID_FLUSH=1, IDEX_FLUSH=1, EX_Hold=0, STALL=0, halted=0. Reset mid-MD_WAIT or in HALT aborts immediately; first cycle after release is RUN.

## Configuration
- MULDIV_STALL_EN defined: IDEX_MulDiv, MD_WAIT and md_cnt are active as above.
- Undefined: IDEX_MulDiv ignored, MD_WAIT unreachable, md_cnt removed, EX_Hold tied 0; ALU ops treated as single-cycle.

## Test plan
- Load R3 in EX (IDEX_MemRead=1, IDEX_RegRD=3), ID uses Fop2=3 -> 1 cycle PCWrite=0, IDEX_FLUSH=1, STALL=1; then RUN; stall_count=1.
- PCSRC=1 with load-use also matching -> IFID_FLUSH=IDEX_FLUSH=1, PCWrite=1, STALL=0, no LD_BUBBLE.
- MULDIV_STALL_EN, MULDIV_CYCLES=4, IDEX_MulDiv=1 -> STALL and EX_Hold high 3 cycles, low on 4th; stall_count=3. Repeat with MULDIV_CYCLES=2 -> exactly 1 stall cycle.
- IFID_opcode=4'hF -> halted=1 next cycle, PCWrite stays 0 for 20 cycles, stall_count unchanged; reset low then high -> RUN, halted=0.
- Reset asserted in MD_WAIT with md_cnt=2 -> outputs at reset values without clock edge; stall_count=0.
- Force 65540 stall cycles -> stall_count holds 16'hFFFF.
